// File: rtl/mc_control.sv
// Multi-cycle sequencing controller for the RV32-subset datapath: fetch/decode/execute FSM,
// run/single-step control, retired-instruction counter and illegal-opcode trap.
// Optional jal support is built when MC_CTRL_JAL_EN is defined.
module mc_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode_i,
    input  logic             zero_i,
    input  logic             run_i,
    input  logic             step_i,
    output logic             pc_we_o,
    output logic             ir_we_o,
    output logic             iord_o,
    output logic             mem_we_o,
    output logic             reg_we_o,
    output logic [1:0]       wb_sel_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             pc_src_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StIf   = 4'd1,
        StId   = 4'd2,
        StMa   = 4'd3,
        StMr   = 4'd4,
        StMw   = 4'd5,
        StWbm  = 4'd6,
        StExr  = 4'd7,
        StExi  = 4'd8,
        StWba  = 4'd9,
        StBeq  = 4'd10,
        StJal  = 4'd11,
        StTrap = 4'd12
    } state_e;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e           state_q, state_d;
    logic             step_q;
    logic             step_rise;
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    logic       pc_we_q, pc_we_d;
    logic       ir_we_q, ir_we_d;
    logic       iord_q, iord_d;
    logic       mem_we_q, mem_we_d;
    logic       reg_we_q, reg_we_d;
    logic [1:0] wb_sel_q, wb_sel_d;
    logic [1:0] alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       pc_src_q, pc_src_d;
    logic       busy_q, busy_d;
    logic       illegal_q, illegal_d;
    logic       in_beq;

    assign step_rise = step_i & ~step_q;

    // Next-state logic; step edges outside IDLE are simply never consumed.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run_i || step_rise) begin
                    state_d = StIf;
                end
            end
            StIf: state_d = StId;
            StId: begin
                case (opcode_i)
                    OpRType:         state_d = StExr;
                    OpIType:         state_d = StExi;
                    OpLoad, OpStore: state_d = StMa;
                    OpBranch:        state_d = StBeq;
`ifdef MC_CTRL_JAL_EN
                    OpJal:           state_d = StJal;
`endif
                    default:         state_d = StTrap;
                endcase
            end
            StMa:         state_d = (opcode_i == OpLoad) ? StMr : StMw;
            StMr:         state_d = StWbm;
            StExr, StExi: state_d = StWba;
            StWbm, StMw, StWba, StBeq, StJal: begin
                retire  = 1'b1;
                state_d = run_i ? StIf : StIdle;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
    end

    // Control word for the state being entered, so the registered outputs match state_q.
    always_comb begin
        pc_we_d     = 1'b0;
        ir_we_d     = 1'b0;
        iord_d      = 1'b0;
        mem_we_d    = 1'b0;
        reg_we_d    = 1'b0;
        wb_sel_d    = 2'd0;
        alu_src_a_d = 2'd0;
        alu_src_b_d = 2'd0;
        alu_op_d    = 2'b00;
        pc_src_d    = 1'b0;
        illegal_d   = 1'b0;
        busy_d      = (state_d != StIdle) && (state_d != StTrap);
        unique case (state_d)
            StIf: begin
                ir_we_d     = 1'b1;
                alu_src_b_d = 2'd1;
                pc_we_d     = 1'b1;
            end
            StId: begin
                alu_src_a_d = 2'd2;
                alu_src_b_d = 2'd2;
            end
            StMa, StExi: begin
                alu_src_a_d = 2'd1;
                alu_src_b_d = 2'd2;
            end
            StMr: iord_d = 1'b1;
            StMw: begin
                iord_d   = 1'b1;
                mem_we_d = 1'b1;
            end
            StWbm: begin
                reg_we_d = 1'b1;
                wb_sel_d = 2'd1;
            end
            StExr: begin
                alu_src_a_d = 2'd1;
                alu_op_d    = 2'b10;
            end
            StWba: reg_we_d = 1'b1;
            StBeq: begin
                alu_src_a_d = 2'd1;
                alu_op_d    = 2'b01;
                pc_src_d    = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            StJal: begin
                reg_we_d = 1'b1;
                wb_sel_d = 2'd2;
                pc_src_d = 1'b1;
                pc_we_d  = 1'b1;
            end
`endif
            StTrap:  illegal_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= 1'b0;
            cnt_q       <= '0;
            pc_we_q     <= 1'b0;
            ir_we_q     <= 1'b0;
            iord_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            wb_sel_q    <= 2'd0;
            alu_src_a_q <= 2'd0;
            alu_src_b_q <= 2'd0;
            alu_op_q    <= 2'b00;
            pc_src_q    <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_i;
            if (retire) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            pc_we_q     <= pc_we_d;
            ir_we_q     <= ir_we_d;
            iord_q      <= iord_d;
            mem_we_q    <= mem_we_d;
            reg_we_q    <= reg_we_d;
            wb_sel_q    <= wb_sel_d;
            alu_src_a_q <= alu_src_a_d;
            alu_src_b_q <= alu_src_b_d;
            alu_op_q    <= alu_op_d;
            pc_src_q    <= pc_src_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_beq = (state_q == StBeq);

    // Write enables are masked during reset so the reset cycle never commits a write.
    assign pc_we_o     = ~rst & (pc_we_q | (in_beq & zero_i));
    assign ir_we_o     = ~rst & ir_we_q;
    assign mem_we_o    = ~rst & mem_we_q;
    assign reg_we_o    = ~rst & reg_we_q;
    assign iord_o      = iord_q;
    assign wb_sel_o    = wb_sel_q;
    assign alu_src_a_o = alu_src_a_q;
    assign alu_src_b_o = alu_src_b_q;
    assign alu_op_o    = alu_op_q;
    assign pc_src_o    = pc_src_q;
    assign busy_o      = busy_q;
    assign illegal_o   = illegal_q;
    assign state_o     = state_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: expected state sequences are queued per instruction and
// compared cycle by cycle against a control-word table and a retire-count model.
module tb_mc_control;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode_i;
    logic        zero_i;
    logic        run_i;
    logic        step_i;
    logic        pc_we_o, ir_we_o, iord_o, mem_we_o, reg_we_o, pc_src_o, busy_o, illegal_o;
    logic [1:0]  wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o;
    logic [3:0]  state_o;
    logic [31:0] instr_cnt_o;
    logic [17:0] ctrl_obs;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 0;
    logic [3:0]  exp_q[$];

    mc_control #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode_i    (opcode_i),
        .zero_i      (zero_i),
        .run_i       (run_i),
        .step_i      (step_i),
        .pc_we_o     (pc_we_o),
        .ir_we_o     (ir_we_o),
        .iord_o      (iord_o),
        .mem_we_o    (mem_we_o),
        .reg_we_o    (reg_we_o),
        .wb_sel_o    (wb_sel_o),
        .alu_src_a_o (alu_src_a_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_op_o    (alu_op_o),
        .pc_src_o    (pc_src_o),
        .busy_o      (busy_o),
        .illegal_o   (illegal_o),
        .state_o     (state_o),
        .instr_cnt_o (instr_cnt_o)
    );

    assign ctrl_obs = {pc_we_o, ir_we_o, iord_o, mem_we_o, reg_we_o, wb_sel_o, alu_src_a_o,
                       alu_src_b_o, alu_op_o, pc_src_o, busy_o, illegal_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic z);
        logic pw, iw, io, mw, rw, ps, bz, il;
        logic [1:0] wb, sa, sb, op;
        {pw, iw, io, mw, rw, ps, bz, il} = '0;
        {wb, sa, sb, op} = '0;
        case (s)
            4'd1:  begin iw = 1; sb = 2'd1; pw = 1; end
            4'd2:  begin sa = 2'd2; sb = 2'd2; end
            4'd3:  begin sa = 2'd1; sb = 2'd2; end
            4'd4:  io = 1;
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin rw = 1; wb = 2'd1; end
            4'd7:  begin sa = 2'd1; op = 2'b10; end
            4'd8:  begin sa = 2'd1; sb = 2'd2; end
            4'd9:  rw = 1;
            4'd10: begin sa = 2'd1; op = 2'b01; ps = 1; pw = z; end
            4'd11: begin rw = 1; wb = 2'd2; ps = 1; pw = 1; end
            4'd12: il = 1;
            default: ;
        endcase
        bz = (s != 4'd0) && (s != 4'd12);
        return {pw, iw, io, mw, rw, wb, sa, sb, op, ps, bz, il};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Push the expected state walk for one instruction, starting at IF.
    task automatic issue(input logic [6:0] op, input logic z);
        opcode_i = op;
        zero_i   = z;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        case (op)
            7'b0000011: begin exp_q.push_back(4'd3); exp_q.push_back(4'd4);
                              exp_q.push_back(4'd6); end
            7'b0100011: begin exp_q.push_back(4'd3); exp_q.push_back(4'd5); end
            7'b0110011: begin exp_q.push_back(4'd7); exp_q.push_back(4'd9); end
            7'b0010011: begin exp_q.push_back(4'd8); exp_q.push_back(4'd9); end
            7'b1100011: exp_q.push_back(4'd10);
`ifdef MC_CTRL_JAL_EN
            7'b1101111: exp_q.push_back(4'd11);
`endif
            default:    exp_q.push_back(4'd12);
        endcase
    endtask

    task automatic push_n(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endtask

    task automatic drain();
        logic [3:0] s;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            cycle();
            check("state", {28'd0, state_o}, {28'd0, s});
            check("ctrl", {14'd0, ctrl_obs}, {14'd0, exp_ctrl(s, zero_i)});
            check("instr_cnt", instr_cnt_o, exp_cnt);
            if (s inside {4'd5, 4'd6, 4'd9, 4'd10, 4'd11}) exp_cnt++;
        end
    endtask

    initial begin
        rst = 1; run_i = 0; step_i = 0; opcode_i = 7'd0; zero_i = 0;
        cycle();
        cycle();
        check("rst_state", {28'd0, state_o}, 32'd0);
        check("rst_ctrl", {14'd0, ctrl_obs}, 32'd0);
        check("rst_cnt", instr_cnt_o, 32'd0);
        rst = 0;
        push_n(4'd0, 2);
        drain();

        // Continuous run: lw, add, beq taken, beq not taken.
        run_i = 1;
        issue(7'b0000011, 1'b0);
        drain();
        issue(7'b0110011, 1'b0);
        drain();
        issue(7'b1100011, 1'b1);
        drain();
        check("cnt_after_lw_add", instr_cnt_o, 32'd2);
        check("beq_taken_pc_we", {31'd0, pc_we_o}, 32'd1);
        issue(7'b1100011, 1'b0);
        drain();
        check("beq_not_taken_pc_we", {31'd0, pc_we_o}, 32'd0);
        run_i = 0;
        push_n(4'd0, 2);
        drain();
        check("cnt_after_beqs", instr_cnt_o, 32'd4);

        // Single step with step held high: exactly one instruction.
        step_i = 1;
        issue(7'b0010011, 1'b0);
        push_n(4'd0, 16);
        drain();
        step_i = 0;
        push_n(4'd0, 1);
        drain();
        step_i = 1;
        issue(7'b0010011, 1'b0);
        push_n(4'd0, 2);
        drain();
        step_i = 0;
        check("cnt_after_steps", instr_cnt_o, 32'd6);

        // Reset in MW: no memory write, counter cleared.
        run_i = 1;
        opcode_i = 7'b0100011;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        drain();
        cycle();
        check("mw_state", {28'd0, state_o}, 32'd5);
        check("mw_mem_we", {31'd0, mem_we_o}, 32'd1);
        rst = 1;
        run_i = 0;
        #1;
        check("mw_rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        cycle();
        rst = 0;
        exp_cnt = 0;
        check("mw_rst_state", {28'd0, state_o}, 32'd0);
        check("mw_rst_cnt", instr_cnt_o, 32'd0);

        // Illegal opcode traps and stays trapped.
        run_i = 1;
        issue(7'b1111111, 1'b0);
        push_n(4'd12, 9);
        drain();
        check("trap_illegal", {31'd0, illegal_o}, 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        run_i = 0;
        check("trap_rst_state", {28'd0, state_o}, 32'd0);
        check("trap_rst_illegal", {31'd0, illegal_o}, 32'd0);

        // jal: executes when built in, traps otherwise.
        run_i = 1;
        issue(7'b1101111, 1'b0);
`ifdef MC_CTRL_JAL_EN
        drain();
        run_i = 0;
        push_n(4'd0, 1);
        drain();
        check("jal_cnt", instr_cnt_o, 32'd1);
`else
        push_n(4'd12, 2);
        drain();
        check("jal_trap_cnt", instr_cnt_o, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle sequencing controller for the RV32 subset CPU datapath (shared instruction/data memory, IR, MDR, A/B, ALUOut registers). It walks each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath write-enable and mux select. It also provides run/single-step control, a retired-instruction counter and an illegal-opcode trap for the debug bus.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  7  IR[6:0] of the instruction currently held in IR
- zero  in  1  ALU zero flag, combinational from the current ALU operation
- run  in  1  level; 1 = execute continuously
- step  in  1  debug step request; each rising edge executes exactly one instruction when run=0
- pc_we  out  1  PC write enable
- ir_we  out  1  IR write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_we  out  1  memory write enable
- reg_we  out  1  register file write enable
- wb_sel  out  2  write-back data: 0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a  out  2  0 = PC, 1 = A, 2 = oldPC
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = immediate
- alu_op  out  2  00 = add, 01 = sub, 10 = decode from funct3/funct7
- pc_src  out  1  0 = ALU result, 1 = ALUOut
- busy  out  1  state is not IDLE and not TRAP
- illegal  out  1  sticky; high in TRAP
- state  out  4  current state code, for debug
- instr_cnt  out  CNT_W  number of retired instructions

## Operation
- State codes: IDLE=0, IF=1, ID=2, MA=3, MR=4, MW=5, WBM=6, EXR=7, EXI=8, WBA=9, BEQ=10, JAL=11, TRAP=12.
- Outputs are decoded from the registered state. The one exception is pc_we in BEQ, which equals zero.
- Any output not listed for a state is 0.
- **IDLE**: go to IF if run=1, or if a step rising edge is seen (step=1 and step_q=0, with step_q a register). Otherwise stay.
- **IF**: ir_we=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0, pc_we=1. Next state ID. Writing oldPC is the datapath's job.
- **ID**: alu_src_a=2, alu_src_b=2, alu_op=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0110011 → EXR
  - 0010011 → EXI
  - 0000011 or 0100011 → MA
  - 1100011 → BEQ
  - 1101111 → JAL (only when the macro is defined)
  - anything else → TRAP
- **MA**: alu_src_a=1, alu_src_b=2, alu_op=00. Next state MR for a load, MW for a store.
- **MR**: iord=1 (MDR is loaded by the datapath). Next state WBM.
- **WBM**: reg_we=1, wb_sel=1. Retire.
- **MW**: iord=1, mem_we=1. Retire.
- **EXR**: alu_src_a=1, alu_src_b=0, alu_op=10. Next state WBA.
- **EXI**: alu_src_a=1, alu_src_b=2, alu_op=00. Next state WBA.
- **WBA**: reg_we=1, wb_sel=0. Retire.
- **BEQ**: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1, pc_we=zero. Retire.
- **JAL**: reg_we=1, wb_sel=2 (PC already equals oldPC+4), pc_src=1, pc_we=1. Retire.
- **Retire** (exit from WBM, MW, WBA, BEQ, JAL): instr_cnt increments by 1, wrapping at 2^CNT_W. Next state is IF if run=1, else IDLE.
- **TRAP**: illegal=1 and all enables 0. Exits only on rst. Trapped instructions are not counted.
- step edges seen while not in IDLE are discarded. Dropping run mid-instruction finishes the current instruction, then the controller goes to IDLE.

## Timing
- Reset values: state=IDLE, every output 0, instr_cnt=0, step_q=0.
- While rst=1, pc_we, ir_we, mem_we and reg_we are forced to 0 combinationally, so no write happens in the reset cycle.
- Reset mid-instruction abandons the instruction. The state is IDLE after the edge.
- Cycles per instruction, IF to retire inclusive: R-type 4, addi 4, lw 5, sw 4, beq 3, jal 3. IDLE adds 1 cycle before IF.
- With run held high, instructions are issued back-to-back: the cycle after retire is IF.
- instr_cnt updates on the edge that leaves the retire state. It is visible in the next cycle.
- A step edge and run=1 in the same IDLE cycle start one instruction. Execution then continues, because run=1.

## Configuration
- MC_CTRL_JAL_EN defined: the JAL state exists and opcode 1101111 executes as jal.
- MC_CTRL_JAL_EN undefined: the JAL state is not built, opcode 1101111 goes to TRAP, and wb_sel never equals 2.

## Test plan
- Reset then run=1 with lw (0000011): states 1,2,3,4,6 in order, reg_we=1 only in WBM. Then lw, add: instr_cnt=2 after 9 cycles of execution.
- beq with zero=1, then with zero=0: pc_we=1 in BEQ for the first, 0 for the second. Both counted, both take 3 cycles.
- run=0, step held high for 20 cycles on addi: exactly one instruction (4 cycles), then IDLE, instr_cnt=1. A second rising edge executes one more.
- opcode 7'b1111111 in ID: TRAP, illegal=1, all enables 0 for 10 cycles, instr_cnt unchanged. rst clears illegal and returns to IDLE.
- rst asserted during MW: mem_we=0 in that cycle, state=0 and instr_cnt=0 afterwards.
- jal with the macro defined: 3 cycles with reg_we=1, wb_sel=2, pc_we=1 in JAL. With the macro undefined: TRAP.
